// File: rtl/branch_hazard_ctrl_pkg.sv
// branch_pkg: shared constants and types for the decode-stage branch
// controller (branch_hazard_ctrl).
//   OP_*      branch opcodes decoded from instr_D[31:26]
//   FWD_*     D-stage operand source select encodings
//   state_e   controller state (run / holding a stalled branch)
//   is_branch / uses_rt  opcode classification helpers
package branch_pkg;

   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_BGTZ = 6'b000111;
   localparam logic [5:0] OP_BGE  = 6'b111111;

   localparam logic [1:0] FWD_GPR = 2'b00;
   localparam logic [1:0] FWD_M   = 2'b01;
   localparam logic [1:0] FWD_W   = 2'b10;

   typedef enum logic {
      ST_RUN,
      ST_HOLD
   } state_e;

   function automatic logic is_branch(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ) || (op == OP_BGE);
   endfunction

   // bgtz compares rs against zero, so its rt field carries no operand
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGE);
   endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// branch_hazard_ctrl_if: pipeline-facing signal bundle of the branch
// controller.
//   instr_D, regwrite/dst/load of E/M/W, cmp_eq, cmp_ge : pipeline -> ctrl
//   stall_D, fwd_rs_D, fwd_rt_D, br_valid, br_taken,
//   err_stall, cnt_branch, cnt_taken, cnt_stall        : ctrl -> pipeline
// Modports: master = pipeline side, slave = controller side.
interface branch_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [31:0]      instr_D;
   logic             regwrite_E;
   logic [4:0]       dst_E;
   logic             regwrite_M;
   logic             load_M;
   logic [4:0]       dst_M;
   logic             regwrite_W;
   logic [4:0]       dst_W;
   logic             cmp_eq;
   logic             cmp_ge;
   logic             stall_D;
   logic [1:0]       fwd_rs_D;
   logic [1:0]       fwd_rt_D;
   logic             br_valid;
   logic             br_taken;
   logic             err_stall;
   logic [CNT_W-1:0] cnt_branch;
   logic [CNT_W-1:0] cnt_taken;
   logic [CNT_W-1:0] cnt_stall;

   modport master (
      output instr_D, regwrite_E, dst_E, regwrite_M, load_M, dst_M,
             regwrite_W, dst_W, cmp_eq, cmp_ge,
      input  stall_D, fwd_rs_D, fwd_rt_D, br_valid, br_taken, err_stall,
             cnt_branch, cnt_taken, cnt_stall
   );

   modport slave (
      input  instr_D, regwrite_E, dst_E, regwrite_M, load_M, dst_M,
             regwrite_W, dst_W, cmp_eq, cmp_ge,
      output stall_D, fwd_rs_D, fwd_rt_D, br_valid, br_taken, err_stall,
             cnt_branch, cnt_taken, cnt_stall
   );
endinterface

// File: rtl/branch_hazard_ctrl_operand_hazard.sv
// branch_operand_hazard: classifies one branch source register against the
// in-flight E/M/W writers.
//   used          operand is read by the branch in D
//   r             source register number
//   regwrite_*, dst_*, load_M   pipeline writer state
//   hazard        operand value not yet obtainable in D
//   fwd           operand source select (FWD_GPR / FWD_M / FWD_W)
import branch_pkg::*;

module branch_operand_hazard (
   input  logic       used,
   input  logic [4:0] r,
   input  logic       regwrite_E,
   input  logic [4:0] dst_E,
   input  logic       regwrite_M,
   input  logic       load_M,
   input  logic [4:0] dst_M,
   input  logic       regwrite_W,
   input  logic [4:0] dst_W,
   output logic       hazard,
   output logic [1:0] fwd
);

   // Youngest writer wins; $0 is hardwired and never waits.
   always_comb begin
      hazard = 1'b0;
      fwd    = FWD_GPR;
      if (used && (r != 5'd0)) begin
         if (regwrite_E && (dst_E == r)) begin
            hazard = 1'b1;
         end else if (regwrite_M && (dst_M == r)) begin
            if (load_M) hazard = 1'b1;
            else        fwd    = FWD_M;
         end else if (regwrite_W && (dst_W == r)) begin
            fwd = FWD_W;
         end
      end
   end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: decode-stage branch controller. Detects RAW hazards on
// branch operands, selects D-stage forwarding, stalls F/D until operands are
// available and emits one resolution pulse (br_valid/br_taken) per branch.
// A watchdog sets sticky err_stall once one branch has stalled MAX_STALL cycles.
// Ports: clk, reset (async, active low), bus (branch_hazard_ctrl_if.slave).
// Parameters: MAX_STALL (watchdog threshold), CNT_W (stats counter width).
// Build option: define BRANCH_STATS_EN to build the branch/taken/stall
// counters; otherwise cnt_* read as zero.
import branch_pkg::*;

module branch_hazard_ctrl #(
   parameter int unsigned MAX_STALL = 3,
   parameter int unsigned CNT_W     = 32
) (
   input logic                 clk,
   input logic                 reset,
   branch_hazard_ctrl_if.slave bus
);

   localparam int unsigned     SC_W      = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
   localparam logic [SC_W-1:0] STALL_MAX = SC_W'(MAX_STALL);

   logic [5:0]      opcode;
   logic            branch;
   logic            rt_used;
   logic            rs_haz, rt_haz;
   logic [1:0]      rs_fwd, rt_fwd;
   logic            hazard;
   logic            stall, valid, taken;
   state_e          state, state_next;
   logic [SC_W-1:0] stall_cnt, stall_cnt_next;
   logic            err_stall, err_next;
   logic            unused_low;

   assign unused_low = ^bus.instr_D[15:0];

   always_comb begin
      opcode  = bus.instr_D[31:26];
      branch  = is_branch(opcode);
      rt_used = branch && uses_rt(opcode);
   end

   branch_operand_hazard u_rs (
      .used       (branch),
      .r          (bus.instr_D[25:21]),
      .regwrite_E (bus.regwrite_E),
      .dst_E      (bus.dst_E),
      .regwrite_M (bus.regwrite_M),
      .load_M     (bus.load_M),
      .dst_M      (bus.dst_M),
      .regwrite_W (bus.regwrite_W),
      .dst_W      (bus.dst_W),
      .hazard     (rs_haz),
      .fwd        (rs_fwd)
   );

   branch_operand_hazard u_rt (
      .used       (rt_used),
      .r          (bus.instr_D[20:16]),
      .regwrite_E (bus.regwrite_E),
      .dst_E      (bus.dst_E),
      .regwrite_M (bus.regwrite_M),
      .load_M     (bus.load_M),
      .dst_M      (bus.dst_M),
      .regwrite_W (bus.regwrite_W),
      .dst_W      (bus.dst_W),
      .hazard     (rt_haz),
      .fwd        (rt_fwd)
   );

   // Outputs are forced quiet while reset is held low, independent of inputs.
   always_comb begin
      hazard = rs_haz || rt_haz;
      stall  = reset && branch && hazard;
      valid  = reset && branch && !hazard;
      taken  = valid && ((opcode == OP_BGE) ? bus.cmp_ge : bus.cmp_eq);
   end

   always_comb begin
      state_next     = state;
      stall_cnt_next = stall_cnt;
      unique case (state)
         ST_RUN: begin
            if (hazard) begin
               state_next     = ST_HOLD;
               stall_cnt_next = SC_W'(1);
            end
         end
         ST_HOLD: begin
            // hazard is zero for a non-branch, so a flush also returns to RUN
            if (hazard) begin
               if (stall_cnt != STALL_MAX) stall_cnt_next = stall_cnt + SC_W'(1);
            end else begin
               state_next     = ST_RUN;
               stall_cnt_next = '0;
            end
         end
         default: begin
            state_next     = ST_RUN;
            stall_cnt_next = '0;
         end
      endcase
      err_next = err_stall || (stall_cnt_next == STALL_MAX);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_RUN;
         stall_cnt <= '0;
         err_stall <= 1'b0;
      end else begin
         state     <= state_next;
         stall_cnt <= stall_cnt_next;
         err_stall <= err_next;
      end
   end

   assign bus.stall_D   = stall;
   assign bus.br_valid  = valid;
   assign bus.br_taken  = taken;
   assign bus.fwd_rs_D  = reset ? rs_fwd : FWD_GPR;
   assign bus.fwd_rt_D  = reset ? rt_fwd : FWD_GPR;
   assign bus.err_stall = err_stall;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] cnt_branch, cnt_taken, cnt_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_branch <= '0;
         cnt_taken  <= '0;
         cnt_stall  <= '0;
      end else begin
         cnt_branch <= cnt_branch + CNT_W'(valid);
         cnt_taken  <= cnt_taken + CNT_W'(taken);
         cnt_stall  <= cnt_stall + CNT_W'(stall);
      end
   end

   assign bus.cnt_branch = cnt_branch;
   assign bus.cnt_taken  = cnt_taken;
   assign bus.cnt_stall  = cnt_stall;
`else
   logic [CNT_W-1:0] cnt_zero;

   assign cnt_zero       = '0;
   assign bus.cnt_branch = cnt_zero;
   assign bus.cnt_taken  = cnt_zero;
   assign bus.cnt_stall  = cnt_zero;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Testbench for branch_hazard_ctrl: two instances (watchdog thresholds 3
// and 1) share one stimulus stream; a behavioural model checks every cycle,
// and directed sequences pin the model with literal expectations.
`timescale 1ns/1ps
module tb_branch_hazard_ctrl;

   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;
   localparam logic [5:0] BGTZ = 6'b000111;
   localparam logic [5:0] BGE  = 6'b111111;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] NOP  = 6'b000000;
`ifdef BRANCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic rst_drv;
   bit   done = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   branch_hazard_ctrl_if #(.CNT_W(32)) bus0 ();
   branch_hazard_ctrl_if #(.CNT_W(32)) bus1 ();

   branch_hazard_ctrl #(.MAX_STALL(3), .CNT_W(32)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   branch_hazard_ctrl #(.MAX_STALL(1), .CNT_W(32)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   always_comb begin
      bus1.instr_D    = bus0.instr_D;
      bus1.regwrite_E = bus0.regwrite_E;
      bus1.dst_E      = bus0.dst_E;
      bus1.regwrite_M = bus0.regwrite_M;
      bus1.load_M     = bus0.load_M;
      bus1.dst_M      = bus0.dst_M;
      bus1.regwrite_W = bus0.regwrite_W;
      bus1.dst_W      = bus0.dst_W;
      bus1.cmp_eq     = bus0.cmp_eq;
      bus1.cmp_ge     = bus0.cmp_ge;
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   int unsigned m_stalls = 0;   // consecutive stall cycles of the current branch
   bit          m_err3 = 1'b0, m_err1 = 1'b0;
   logic [31:0] m_cb = '0, m_ct = '0, m_cs = '0;

   function automatic void operand(input logic [4:0] r, output bit haz, output logic [1:0] f);
      haz = 1'b0;
      f   = 2'b00;
      if (r == 5'd0) return;
      if (bus0.regwrite_E && bus0.dst_E == r) haz = 1'b1;
      else if (bus0.regwrite_M && bus0.dst_M == r && bus0.load_M) haz = 1'b1;
      else if (bus0.regwrite_M && bus0.dst_M == r) f = 2'b01;
      else if (bus0.regwrite_W && bus0.dst_W == r) f = 2'b10;
   endfunction

   always begin
      logic [5:0] op;
      bit         is_br, two_op, hs, ht, e_stall, e_valid, e_taken;
      logic [1:0] fs, ft;
      @(negedge clk);
      #3;
      if (!done) begin
         if (!reset) begin
            m_stalls = 0; m_err3 = 1'b0; m_err1 = 1'b0;
            m_cb = '0; m_ct = '0; m_cs = '0;
         end
         op     = bus0.instr_D[31:26];
         is_br  = (op == BEQ) || (op == BNE) || (op == BGTZ) || (op == BGE);
         two_op = (op != BGTZ);
         operand(bus0.instr_D[25:21], hs, fs);
         operand(bus0.instr_D[20:16], ht, ft);
         if (!two_op) begin ht = 1'b0; ft = 2'b00; end
         if (!reset || !is_br) begin
            hs = 1'b0; ht = 1'b0; fs = 2'b00; ft = 2'b00;
         end
         e_stall = reset && is_br && (hs || ht);
         e_valid = reset && is_br && !(hs || ht);
         e_taken = e_valid && ((op == BGE) ? bus0.cmp_ge : bus0.cmp_eq);

         chk("m_stall",  32'(bus0.stall_D),  32'(e_stall));
         chk("m_fwd_rs", 32'(bus0.fwd_rs_D), 32'(fs));
         chk("m_fwd_rt", 32'(bus0.fwd_rt_D), 32'(ft));
         chk("m_valid",  32'(bus0.br_valid), 32'(e_valid));
         chk("m_taken",  32'(bus0.br_taken), 32'(e_taken));
         chk("m_stall1", 32'(bus1.stall_D),  32'(e_stall));
         chk("m_err3",   32'(bus0.err_stall), 32'(m_err3));
         chk("m_err1",   32'(bus1.err_stall), 32'(m_err1));
         chk("m_cnt_branch", bus0.cnt_branch, STATS ? m_cb : 32'd0);
         chk("m_cnt_taken",  bus0.cnt_taken,  STATS ? m_ct : 32'd0);
         chk("m_cnt_stall",  bus0.cnt_stall,  STATS ? m_cs : 32'd0);

         // advance to the state after the coming rising edge
         if (reset) begin
            m_stalls = e_stall ? m_stalls + 1 : 0;
            if (m_stalls >= 3) m_err3 = 1'b1;
            if (m_stalls >= 1) m_err1 = 1'b1;
            m_cb += 32'(e_valid);
            m_ct += 32'(e_taken);
            m_cs += 32'(e_stall);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic rw_e, input logic [4:0] d_e,
                      input logic rw_m, input logic ld_m, input logic [4:0] d_m,
                      input logic rw_w, input logic [4:0] d_w,
                      input logic eq, input logic ge);
      @(negedge clk);
      reset           = rst_drv;
      bus0.instr_D    = {op, rs, rt, 16'h1234};
      bus0.regwrite_E = rw_e;  bus0.dst_E = d_e;
      bus0.regwrite_M = rw_m;  bus0.load_M = ld_m;  bus0.dst_M = d_m;
      bus0.regwrite_W = rw_w;  bus0.dst_W = d_w;
      bus0.cmp_eq     = eq;    bus0.cmp_ge = ge;
      #4;
   endtask

   task automatic out_chk(input string name, input logic st, input logic [1:0] frs,
                          input logic [1:0] frt, input logic v, input logic t);
      chk({name, "_stall"},  32'(bus0.stall_D),  32'(st));
      chk({name, "_fwd_rs"}, 32'(bus0.fwd_rs_D), 32'(frs));
      chk({name, "_fwd_rt"}, 32'(bus0.fwd_rt_D), 32'(frt));
      chk({name, "_valid"},  32'(bus0.br_valid), 32'(v));
      chk({name, "_taken"},  32'(bus0.br_taken), 32'(t));
   endtask

   initial begin
      logic [5:0] ops [6];
      ops = '{BEQ, BNE, BGTZ, BGE, LW, NOP};
      rst_drv = 1'b0;
      reset   = 1'b0;
      cyc(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // hazard inputs during reset must not reach the outputs
      cyc(BEQ, 1, 2, 1, 1, 0, 0, 0, 1, 2, 1, 0);
      out_chk("rst", 0, 2'b00, 2'b00, 0, 0);
      chk("rst_err1", 32'(bus1.err_stall), 32'd0);
      chk("rst_cnt", bus0.cnt_branch, 32'd0);
      rst_drv = 1'b1;

      // beq $1,$2 with $1 in E: one stall, then M-forwarded resolution
      cyc(BEQ, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0);
      out_chk("beq_e", 1, 2'b00, 2'b00, 0, 0);
      cyc(BEQ, 1, 2, 0, 0, 1, 0, 1, 0, 0, 1, 0);
      out_chk("beq_m", 0, 2'b01, 2'b00, 1, 1);
      chk("wd1_err", 32'(bus1.err_stall), 32'd1);

      // lw $3 through E then M, bne $3,$0: two stalls then W forward
      cyc(BNE, 3, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1);
      out_chk("bne_e", 1, 2'b00, 2'b00, 0, 0);
      cyc(BNE, 3, 0, 0, 0, 1, 1, 3, 0, 0, 0, 1);
      out_chk("bne_ld", 1, 2'b00, 2'b00, 0, 0);
      cyc(BNE, 3, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1);
      out_chk("bne_w", 0, 2'b10, 2'b00, 1, 0);
      chk("wd3_legal", 32'(bus0.err_stall), 32'd0);

      // bgtz ignores its rt field
      cyc(BGTZ, 4, 5, 1, 5, 1, 0, 5, 0, 0, 1, 0);
      out_chk("bgtz", 0, 2'b00, 2'b00, 1, 1);
      // $0 never hazards
      cyc(BEQ, 0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0);
      out_chk("beq0", 0, 2'b00, 2'b00, 1, 1);
      // bge resolves on cmp_ge
      cyc(BGE, 7, 8, 0, 0, 0, 0, 0, 1, 8, 0, 1);
      out_chk("bge_t", 0, 2'b00, 2'b10, 1, 1);
      cyc(BGE, 7, 8, 0, 0, 1, 0, 7, 1, 8, 1, 0);
      out_chk("bge_n", 0, 2'b01, 2'b10, 1, 0);
      // non-branch: no stall, no forwarding, no resolution
      cyc(LW, 1, 2, 1, 1, 1, 0, 2, 0, 0, 1, 1);
      out_chk("nonbr", 0, 2'b00, 2'b00, 0, 0);

      // runaway stall trips the MAX_STALL=3 watchdog after the third edge
      for (int i = 0; i < 3; i++) begin
         cyc(BEQ, 6, 9, 1, 6, 0, 0, 0, 0, 0, 0, 0);
         chk("wd3_pre", 32'(bus0.err_stall), 32'd0);
      end
      cyc(BEQ, 6, 9, 1, 6, 0, 0, 0, 0, 0, 0, 0);
      chk("wd3_set", 32'(bus0.err_stall), 32'd1);
      chk("wd3_stall", 32'(bus0.stall_D), 32'd1);
      // reset mid-HOLD clears everything immediately
      rst_drv = 1'b0;
      cyc(BEQ, 6, 9, 1, 6, 0, 0, 0, 0, 0, 0, 0);
      out_chk("rst_hold", 0, 2'b00, 2'b00, 0, 0);
      chk("rst_err3", 32'(bus0.err_stall), 32'd0);
      chk("rst_err1b", 32'(bus1.err_stall), 32'd0);
      rst_drv = 1'b1;

      // 3 branches, 2 taken, 3 stall cycles
      cyc(BEQ, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0);
      cyc(BEQ, 1, 2, 0, 0, 1, 0, 1, 0, 0, 1, 0);
      cyc(BNE, 3, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      cyc(BNE, 3, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0);
      cyc(BNE, 3, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
      cyc(BEQ, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("st_branch", bus0.cnt_branch, STATS ? 32'd3 : 32'd0);
      chk("st_taken",  bus0.cnt_taken,  STATS ? 32'd2 : 32'd0);
      chk("st_stall",  bus0.cnt_stall,  STATS ? 32'd3 : 32'd0);

      // randomized traffic on a small register window to provoke collisions
      for (int n = 0; n < 3000; n++) begin
         rst_drv = ($urandom_range(0, 79) != 0);
         cyc(ops[$urandom_range(0, 5)],
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
             1'($urandom), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom));
      end

      @(negedge clk);
      done = 1'b1;
      #6;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
